// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit over word-only memory (read-modify-write for sub-word stores)
// Optional misaligned-access faulting is enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_isStore,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_fault,
  output logic [ADDR_W-1:0] o_memAddress,
  output logic              o_memWriteEnable,
  output logic [31:0]       o_memWriteData,
  input  logic [31:0]       i_memReadData
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic              r_isStore;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [31:0]       r_wword;
  logic [31:0]       r_rdata;
  logic              r_fault;

  logic              w_illegal;
  logic              w_misalign;
  logic              w_fault;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_loadval;
  logic [31:0]       w_merged;

  // Stores only have B/H/W encodings; loads additionally allow BU/HU.
  assign w_illegal = i_isStore ? (i_funct3[2] | (i_funct3[1:0] == 2'b11))
                               : ((i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                      ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault = w_illegal | w_misalign;

  assign w_byte = i_memReadData[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = i_memReadData[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_loadval = i_memReadData;
    case (r_funct3)
      3'b000:  w_loadval = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_loadval = {24'd0, w_byte};
      3'b001:  w_loadval = {{16{w_half[15]}}, w_half};
      3'b101:  w_loadval = {16'd0, w_half};
      default: w_loadval = i_memReadData;
    endcase
  end

  always_comb begin
    w_merged = i_memReadData;
    if (r_funct3[0] == 1'b0) w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else                     w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_isStore <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= '0;
      r_wdata   <= 16'd0;
      r_wword   <= 32'd0;
      r_rdata   <= 32'd0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_isStore <= i_isStore;
            r_funct3  <= i_funct3;
            r_addr    <= i_addr;
            r_wdata   <= i_wdata[15:0];
            r_fault   <= w_fault;
            if (w_fault) begin
              if (!i_isStore) r_rdata <= 32'd0;
              r_state <= S_DONE;
            end else if (i_isStore && (i_funct3 == 3'b010)) begin
              r_wword <= i_wdata;
              r_state <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (r_isStore) begin
            r_wword <= w_merged;
            r_state <= S_WRITE;
          end else begin
            r_rdata <= w_loadval;
            r_state <= S_DONE;
          end
        end
        S_WRITE: r_state <= S_DONE;
        default: begin
          r_fault <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write strobe decodes straight from the async-reset state, so reset kills it without an edge.
  assign o_ready          = (r_state == S_IDLE);
  assign o_done           = (r_state == S_DONE);
  assign o_fault          = (r_state == S_DONE) & r_fault;
  assign o_rdata          = r_rdata;
  assign o_memWriteEnable = (r_state == S_WRITE);
  assign o_memWriteData   = r_wword;
  assign o_memAddress     = (r_state == S_IDLE) ? {i_addr[ADDR_W-1:2], 2'b00}
                                                : {r_addr[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        tb_wr = 1'b0;
  logic [5:0]  tb_wa = 6'd0;
  logic [31:0] tb_wd = 32'd0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = 32'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_ready(ready),
    .i_isStore(is_store), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_done(done), .o_rdata(rdata), .o_fault(fault),
    .o_memAddress(mem_addr), .o_memWriteEnable(mem_we),
    .o_memWriteData(mem_wdata), .i_memReadData(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
    end else if (tb_wr) begin
      mem[tb_wa] <= tb_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_wr = 1'b1; tb_wa = a[7:2]; tb_wd = d;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  task automatic start(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic op(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] er, input logic ef, input int lat);
    sb.push_back('{tag, er, ef, lat});
    start(st, f3, a, wd);
  endtask

  task automatic finish_op();
    exp_t e;
    int   k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 20);
    e = sb.pop_front();
    check({e.tag, "_timeout"}, 32'(done), 32'd1);
    check({e.tag, "_latency"}, k, e.lat);
    check({e.tag, "_rdata"}, rdata, e.rdata);
    check({e.tag, "_fault"}, 32'(fault), 32'(e.fault));
    @(negedge clk);
    check({e.tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int w0;
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    for (int i = 0; i < 64; i++) begin
      poke(8'(i * 4), 32'd0);
    end
    poke(8'h10, 32'h8899AABB);
    poke(8'h20, 32'h11223344);
    poke(8'h40, 32'h13579BDF);
    @(negedge clk);
    rst_n = 1'b1;

    op("lb", 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2); finish_op();
    op("lbu", 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2); finish_op();
    op("lh", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2); finish_op();
    op("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 2); finish_op();

    w0 = wr_cnt;
    op("sb", 1'b1, 3'b000, 32'h22, 32'h000000EE, 32'h00008899, 1'b0, 3); finish_op();
    check("sb_writes", wr_cnt - w0, 1);
    check("sb_word", mem[8], 32'h11EE3344);
    op("sh", 1'b1, 3'b001, 32'h20, 32'h0000CAFE, 32'h00008899, 1'b0, 3); finish_op();
    check("sh_word", mem[8], 32'h11EECAFE);

    w0 = wr_cnt;
    op("sw", 1'b1, 3'b010, 32'h3C, 32'hDEADBEEF, 32'h00008899, 1'b0, 2); finish_op();
    check("sw_writes", wr_cnt - w0, 1);
    check("sw_addr", last_wa, 32'h3C);
    op("lw", 1'b0, 3'b010, 32'h3C, 32'h0, 32'hDEADBEEF, 1'b0, 2); finish_op();

    w0 = wr_cnt;
    op("st_ill", 1'b1, 3'b100, 32'h30, 32'h12345678, 32'hDEADBEEF, 1'b1, 1); finish_op();
    check("st_ill_nowrite", wr_cnt - w0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    op("lw_mis", 1'b0, 3'b010, 32'h41, 32'h0, 32'h00000000, 1'b1, 1); finish_op();
    w0 = wr_cnt;
    op("sh_mis", 1'b1, 3'b001, 32'h41, 32'h0000FFFF, 32'h00000000, 1'b1, 1); finish_op();
    check("sh_mis_nowrite", wr_cnt - w0, 0);
    check("sh_mis_word", mem[16], 32'h13579BDF);
`else
    op("lw_mis", 1'b0, 3'b010, 32'h41, 32'h0, 32'h13579BDF, 1'b0, 2); finish_op();
`endif
    op("ld_ill", 1'b0, 3'b011, 32'h10, 32'h0, 32'h00000000, 1'b1, 1); finish_op();
    check("ws_unchanged", wr_cnt - w0, 0);

    // Back-to-back: request held high from SB straight into LW.
    sb.push_back('{"b2b_sb", 32'h00000000, 1'b0, 3});
    sb.push_back('{"b2b_lw", 32'h8899AA55, 1'b0, 2});
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h10; wdata = 32'h55;
    @(posedge clk);
    #1 is_store = 1'b0; funct3 = 3'b010;
    finish_op();
    check("b2b_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 req = 1'b0;
    finish_op();
    check("b2b_word", mem[4], 32'h8899AA55);

    // Reset asserted while the SB write strobe is high.
    w0 = wr_cnt;
    start(1'b1, 3'b000, 32'h20, 32'h77);
    @(negedge clk);
    @(negedge clk);
    check("rmid_we_before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmid_we_after", 32'(mem_we), 32'd0);
    check("rmid_ready", 32'(ready), 32'd1);
    check("rmid_rdata", rdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rmid_nowrite", wr_cnt - w0, 0);
    check("rmid_word", mem[8], 32'h11EECAFE);
    op("rmid_lw", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11EECAFE, 1'b0, 2); finish_op();

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the multi-cycle core's datapath and the unified instruction/data memory. Memory is word-only, has a synchronous write and an asynchronous read.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory accesses.
- Sub-word stores use read-modify-write. Loads are lane-selected and sign- or zero-extended.
- One request in flight, with a valid/ready request handshake and a one-cycle done pulse.

Parameters:
- ADDR_W, 32, width of the byte address from the core and to the memory.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_req  input  1  core request valid.
- o_ready  output  1  unit idle and able to accept a request.
- i_isStore  input  1  1 = store, 0 = load.
- i_funct3  input  3  RV32I width/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  input  ADDR_W  byte address.
- i_wdata  input  32  store data, right-justified.
- o_done  output  1  one-cycle pulse when the operation completes.
- o_rdata  output  32  extended load result; valid while o_done=1.
- o_fault  output  1  valid with o_done; misaligned access or illegal funct3.
- o_memAddress  output  ADDR_W  word-aligned address to memory; low 2 bits always 0.
- o_memWriteEnable  output  1  memory write strobe.
- o_memWriteData  output  32  full word to write.
- i_memReadData  input  32  combinational read data for o_memAddress.

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- Reset (asynchronous, i_rst_n=0):
  - state=IDLE, all latched registers 0.
  - o_ready=1; o_done=0, o_fault=0, o_rdata=0.
  - o_memWriteEnable=0, o_memAddress=0, o_memWriteData=0.
  - Reset during READ or WRITE deasserts o_memWriteEnable immediately, with no clock edge needed. No partial write occurs after reset.
- IDLE:
  - o_ready=1. On i_req=1 at an edge, latch i_isStore, i_funct3, i_addr, i_wdata.
  - Next state: LW or any sub-word access → READ; SW → WRITE; fault → DONE.
  - i_req while not in IDLE is ignored; the core holds the request until it sees o_ready.
- READ:
  - o_memAddress={addr[ADDR_W-1:2],2'b00}. i_memReadData is captured at the end of the cycle.
  - Load: extract the lane, extend, register into o_rdata, → DONE.
  - SB/SH: merge the new lane into the captured word, → WRITE.
- WRITE:
  - o_memWriteEnable=1 for exactly one cycle, with o_memAddress and the merged or full word. → DONE.
- DONE:
  - o_done=1 for one cycle with o_rdata and o_fault valid. → IDLE.
  - o_rdata holds its value until the next load completes.
  - Stores leave o_rdata unchanged.
- Lane rules:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend from bit 7/15 of the lane; BU/HU zero-extend.
  - SB replaces bits [8*addr[1:0] +: 8]; SH replaces bits [16*addr[1] +: 16]. Other bytes are preserved from the READ value.
- Latency (request accepted at edge N):
  - Load: o_done at cycle N+2.
  - SW: write in N+1, o_done in N+2.
  - SB/SH: read in N+1, write in N+2, o_done in N+3.
  - Fault: o_done=1, o_fault=1 in N+1, with no memory write.
- Fault conditions:
  - Illegal funct3: load 011/110/111; store anything other than 000/001/010.
  - Misalignment: see Optional Feature.
  - On a faulted load, o_rdata is set to 0.
- Outside WRITE, o_memWriteEnable=0. In IDLE, o_memAddress follows the word-aligned i_addr.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0, takes the fault path. o_fault=1 and memory is untouched.
- Undefined:
  - Misalignment never faults; o_fault flags only illegal funct3.
  - Words use addr[1:0] forced to 00; halves use addr[0] forced to 0.

Test Plan:
- Reset mid-SB (assert i_rst_n=0 during WRITE) → o_memWriteEnable drops asynchronously, state IDLE, o_ready=1, memory word unchanged.
- Memory[0x10]=0x8899AABB; LB addr 0x11 → o_rdata=0xFFFFFFAA at N+2; LBU 0x11 → 0x000000AA; LH 0x12 → 0xFFFF8899; LHU 0x12 → 0x00008899.
- Memory[0x20]=0x11223344; SB addr 0x22 wdata 0x000000EE → exactly one write at N+2 of 0x11EE3344, o_done at N+3; SH 0x20 wdata 0xCAFE → word 0x11EECAFE.
- SW addr 0x3C wdata 0xDEADBEEF → write at N+1 to o_memAddress 0x3C, o_done at N+2; a following LW 0x3C returns 0xDEADBEEF.
- LSU_MISALIGN_CHECK_EN defined: LW 0x41 → o_done+o_fault at N+1, o_rdata=0, no write. Undefined: LW 0x41 reads word 0x40, o_fault=0. Either build: load funct3=011 → o_fault=1.
- Back-to-back: i_req held high across SB then LW → second request accepted only when o_ready=1 after DONE; no overlap of memory accesses.
